// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: address/data widths, reset vector, PC step, bubble instruction.
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

    // Bubbles carry an all-zero instruction word so IF/ID and decode see a harmless value.
    localparam logic [DATA_W-1:0] INST_NOP = '0;

    function automatic logic [ADDR_W-1:0] pc_next_seq(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect control in, instruction-memory port, and the IF/ID output pair.
interface instr_fetch_stage_if;
    import cpu_pkg::*;

    logic              stall;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;
    logic              out_valid;

    modport master (
        input  stall,
        input  redirect_en,
        input  redirect_pc,
        output imem_addr,
        input  imem_rdata,
        output out_pc,
        output out_inst,
        output out_valid
    );

    modport slave (
        output stall,
        output redirect_en,
        output redirect_pc,
        input  imem_addr,
        output imem_rdata,
        input  out_pc,
        input  out_inst,
        input  out_valid
    );

endinterface

// File: rtl/instr_fetch_stage_pc_reg.sv
// Program counter register: reset vector, redirect load, sequential advance when enabled.
// Latency: new PC visible the cycle after the controlling edge.
// Backpressure: en=0 holds the PC; load overrides en; rst overrides everything.
module pc_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              en,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (en) begin
            pc <= pc_next_seq(pc);
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: drives imem with pc_f and pairs the returned word with its PC for IF/ID.
// Latency: address issued in cycle N appears on out_* in cycle N+1; redirect costs one bubble.
// Backpressure: stall freezes PC and outputs, capturing imem data so nothing is lost or repeated.
module instr_fetch_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    instr_fetch_stage_if.master bus
);

    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] req_pc;
    logic              req_valid;
    logic [DATA_W-1:0] hold_inst;
    logic              hold_valid;
    logic              pc_en;

    assign pc_en = ~bus.stall;

    pc_reg u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.redirect_en),
        .load_pc (bus.redirect_pc),
        .en      (pc_en),
        .pc      (pc_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc     <= RESET_PC;
            req_valid  <= 1'b0;
            hold_inst  <= INST_NOP;
            hold_valid <= 1'b0;
        end else if (bus.redirect_en) begin
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
        end else if (bus.stall) begin
            // The memory output follows the held pc_f, not req_pc, so grab it on the first stalled edge.
            if (req_valid && !hold_valid) begin
                hold_inst  <= bus.imem_rdata;
                hold_valid <= 1'b1;
            end
        end else begin
            req_pc     <= pc_f;
            req_valid  <= 1'b1;
            hold_valid <= 1'b0;
        end
    end

    assign bus.imem_addr = pc_f;
    assign bus.out_pc    = req_pc;
    assign bus.out_valid = req_valid;

    always_comb begin
        bus.out_inst = INST_NOP;
        if (hold_valid) begin
            bus.out_inst = hold_inst;
        end else if (req_valid) begin
            bus.out_inst = bus.imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table plus randomized run against a stream-level model.
module tb_instr_fetch_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_fetch_stage_if bus ();

    instr_fetch_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) bus.imem_rdata <= mem_f(bus.imem_addr);

    typedef struct {
        logic        r;
        logic        s;
        logic        d;
        logic [31:0] tgt;
        logic        exp_valid;
        logic        chk_pc;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] tgt,
                                input logic v, input logic cp, input logic [31:0] pc,
                                input logic [31:0] addr);
        vec_t x;
        x.r = r; x.s = s; x.d = d; x.tgt = tgt;
        x.exp_valid = v; x.chk_pc = cp; x.exp_pc = pc; x.exp_addr = addr;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    // Drive inputs at the negedge, let one posedge pass, then return at the next negedge.
    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] tgt);
        rst             = r;
        bus.stall       = s;
        bus.redirect_en = d;
        bus.redirect_pc = tgt;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream model: the stage shows the instruction at the last address it issued, or a bubble.
    logic [31:0] m_next;
    logic [31:0] m_pc;
    logic        m_valid;

    task automatic model_edge(input logic r, input logic s, input logic d, input logic [31:0] tgt);
        if (r) begin
            m_next  = RESET_PC;
            m_pc    = RESET_PC;
            m_valid = 1'b0;
        end else if (d) begin
            m_next  = tgt;
            m_valid = 1'b0;
        end else if (!s) begin
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = m_next + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] exp_inst;
        logic        r, s, d;
        logic [31:0] tgt;

        rst = 1'b1; bus.stall = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
        @(negedge clk);

        //                 r  s  d  target         v  cp pc             addr
        tbl.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h4,         32'h8));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h8,         32'hC));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 1, 32'h8,         32'hC));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 1, 32'h8,         32'hC));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 1, 32'h8,         32'hC));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'hC,         32'h10));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h10,        32'h14));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h14,        32'h18));
        tbl.push_back(mk(0, 0, 1, 32'h100,       0, 0, 32'h0,         32'h100));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h104,       32'h108));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 1, 32'h104,       32'h108));
        tbl.push_back(mk(0, 1, 1, 32'h200,       0, 0, 32'h0,         32'h200));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h200,       32'h204));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h204,       32'h208));
        tbl.push_back(mk(0, 0, 1, 32'h40,        0, 0, 32'h0,         32'h40));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h40,        32'h44));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 1, 32'h40,        32'h44));
        tbl.push_back(mk(1, 1, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 1, 32'h80,        0, 0, 32'h0,         32'h80));
        tbl.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h80));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h80,        32'h84));
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,         32'hFFFF_FFF8));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h4,         32'h8));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].tgt);
            exp_inst = tbl[i].exp_valid ? mem_f(tbl[i].exp_pc) : 32'h0;
            check($sformatf("vec%0d out_valid", i), {31'h0, bus.out_valid}, {31'h0, tbl[i].exp_valid});
            check($sformatf("vec%0d imem_addr", i), bus.imem_addr, tbl[i].exp_addr);
            check($sformatf("vec%0d out_inst", i), bus.out_inst, exp_inst);
            if (tbl[i].chk_pc)
                check($sformatf("vec%0d out_pc", i), bus.out_pc, tbl[i].exp_pc);
        end

        // Randomized run; the first cycle is a reset so the model starts in step with the DUT.
        model_edge(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 99) < 2);
            d   = ($urandom_range(0, 99) < 10);
            s   = ($urandom_range(0, 99) < 30);
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) tgt = {tgt[31:2], 2'b00};
            cycle(r, s, d, tgt);
            model_edge(r, s, d, tgt);
            exp_inst = m_valid ? mem_f(m_pc) : 32'h0;
            check($sformatf("rnd%0d out_valid", n), {31'h0, bus.out_valid}, {31'h0, m_valid});
            check($sformatf("rnd%0d imem_addr", n), bus.imem_addr, m_next);
            check($sformatf("rnd%0d out_inst", n), bus.out_inst, exp_inst);
            if (m_valid)
                check($sformatf("rnd%0d out_pc", n), bus.out_pc, m_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline buffer.
- Owns the program counter and issues addresses to a synchronous instruction memory (1-cycle read latency).
- Pairs each returned instruction with its PC and a valid flag and presents the pair to IF/ID.
- Supports pipeline stall (hold) and branch/jump redirect (squash plus new PC).

Parameters:
ADDR_W, 32, PC and instruction-memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold the fetch output and PC this cycle
redirect_en  input  1  taken branch/jump from a later stage
redirect_pc  input  ADDR_W  target address, valid when redirect_en=1
imem_addr  output  ADDR_W  address to instruction memory (combinational from pc_f)
imem_rdata  input  DATA_W  memory data for the address presented on the previous cycle
out_pc  output  ADDR_W  PC of the instruction on out_inst (to IF/ID)
out_inst  output  DATA_W  fetched instruction (to IF/ID)
out_valid  output  1  out_pc/out_inst hold a real instruction; 0 means bubble

Behaviour:
- State: pc_f (address issued this cycle), req_pc (address issued last cycle), req_valid, hold_inst, hold_valid.
- imem_addr = pc_f at all times, including during reset.
- out_pc = req_pc; out_valid = req_valid.
- out_inst = hold_inst if hold_valid, else imem_rdata if req_valid, else 0.
- Reset (rst=1 at posedge): pc_f<=RESET_PC, req_pc<=RESET_PC, req_valid<=0, hold_valid<=0, hold_inst<=0.
  - Post-reset outputs: out_valid=0, out_inst=0, out_pc=RESET_PC.
  - rst has priority over everything; mid-operation reset discards all in-flight fetches.
- Per-posedge priority (rst=0): redirect_en > stall > normal advance.
- Normal (stall=0, redirect_en=0): req_pc<=pc_f, req_valid<=1, pc_f<=pc_f+PC_STEP, hold_valid<=0.
- Stall (stall=1, redirect_en=0): pc_f, req_pc and req_valid hold.
  - If req_valid=1 and hold_valid=0: hold_inst<=imem_rdata, hold_valid<=1. This captures the data before the memory output changes.
  - Outputs stay constant for the whole stall, any length.
- Stall release: on the first non-stall cycle the held instruction is still presented, and the edge advances normally.
  - The memory read of pc_f during that cycle is returned the next cycle. No instruction is lost or duplicated.
- Redirect (redirect_en=1, regardless of stall): pc_f<=redirect_pc, req_valid<=0, hold_valid<=0.
  - Next cycle: out_valid=0 (one bubble) and imem_addr=redirect_pc.
  - The cycle after that: out_valid=1, out_pc=redirect_pc.
  - Redirect penalty is 1 bubble cycle from this stage.
- Stall with req_valid=0: stays a bubble, no capture.
- Arithmetic: pc_f+PC_STEP is modulo 2^ADDR_W; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- redirect_pc is used unmodified; no alignment check.
- Latency: an address is issued at cycle N; its instruction appears on out_inst/out_pc/out_valid during cycle N+1.

Decomposition:
- Package cpu_pkg: ADDR_W, DATA_W, RESET_PC, PC_STEP, and the NOP/zero instruction constant used for bubbles (shared with IF/ID and decode).
- One natural sub-module, pc_reg: PC register with reset value, load (redirect) and enable (not stall).
- Hold/valid logic stays inline in instr_fetch_stage.

Test Plan:
- Reset, then free run with imem returning mem[a]=a^32'hA5A5_0000:
  - cycle after reset release: out_valid=0.
  - next cycles: out_pc=0,4,8,… with matching out_inst, one per cycle.
- Stall for 3 cycles while out_pc=8:
  - out_pc=8 and out_inst=mem[8] constant throughout, imem_addr=12 constant.
  - after release: out_pc=8 once more, then 12 and 16; no skip, no duplicate beyond the stalled slot.
- redirect_en=1 with redirect_pc=32'h100 while out_pc=20:
  - next cycle: out_valid=0.
  - following cycles: out_pc=32'h100, 32'h104 with correct data.
- redirect_en=1 and stall=1 in the same cycle, target 32'h200:
  - redirect wins: bubble next cycle, then out_pc=32'h200.
  - any stale hold_inst is discarded.
- rst asserted for one cycle mid-stream (out_pc=32'h40, stall=1):
  - next cycle: out_valid=0, imem_addr=0.
  - then out_pc=0 with mem[0].
- Wrap: redirect to 32'hFFFF_FFF8, free run → out_pc=FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
